icache_loader: RTL and testbench
================================

ICACHE_LOADER -- requirements
Module: icache_loader

Interface
REQ-001 SHALL have parameter LOAD_WORDS, default 32, number of instructions written per load (legal 1..32).
REQ-002 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port start  input  1  request a load; sampled only in IDLE.
REQ-005 SHALL have port base_addr  input  address (5)  first icache entry to write; latched on accepted start.
REQ-006 SHALL have port in_valid  input  1  byte-stream valid.
REQ-007 SHALL have port in_data  input  8  byte-stream data.
REQ-008 SHALL have port in_ready  output  1  byte-stream ready.
REQ-009 SHALL have port write  output  1  icache write enable.
REQ-010 SHALL have port write_addr  output  address (5)  icache write address.
REQ-011 SHALL have port write_data  output  instruction (32)  icache write data.
REQ-012 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-013 SHALL have port done  output  1  one-cycle pulse at load completion.

Function
REQ-014 SHALL implement FSM states IDLE, COLLECT, WRITE, DONE.
REQ-015 IDLE: start=1 SHALL latch base_addr into addr register, clear byte and word counters, go COLLECT next cycle.
REQ-016 COLLECT: in_ready SHALL be 1; byte transfer occurs only when in_valid=1 and in_ready=1 on a rising edge.
REQ-017 Byte assembly SHALL be little-endian: byte k of a word (k=0..3) lands in bits 8k+7:8k.
REQ-018 Acceptance of byte 3 SHALL move FSM to WRITE next cycle; bytes 0..2 keep FSM in COLLECT.
REQ-019 WRITE: write SHALL be 1 for exactly one cycle with write_addr=addr and write_data=assembled word; in_ready SHALL be 0.
REQ-020 Latency: write SHALL assert in the cycle immediately after byte 3 is accepted.
REQ-021 After WRITE, addr SHALL increment modulo 32 (31 wraps to 0) and word counter SHALL increment.
REQ-022 After WRITE, FSM SHALL go DONE if the word just written was word LOAD_WORDS-1, else COLLECT.
REQ-023 DONE: done SHALL be 1 for one cycle, in_ready 0, then FSM returns to IDLE.
REQ-024 in_ready SHALL be 0 in IDLE, WRITE, DONE; bytes presented then SHALL NOT be consumed.
REQ-025 start outside IDLE SHALL be ignored with no effect on state, addr or counters.
REQ-026 write, write_addr, write_data, in_ready, busy, done SHALL be derived from registered state only (no combinational path from any input).
REQ-027 write_addr and write_data SHALL hold their last value when write=0.
REQ-028 Minimum throughput SHALL be 5 cycles per word with in_valid continuously high.

Reset
REQ-029 rst=1 at a rising edge SHALL force IDLE regardless of state, including mid-word or during WRITE.
REQ-030 Reset values: in_ready=0, write=0, write_addr=0, write_data=0, busy=0, done=0; addr, counters, assembly register =0.
REQ-031 A partially assembled word at reset SHALL be discarded and never written.
REQ-032 rst SHALL take priority over start in the same cycle.

Verification
REQ-033 LOAD_WORDS=2, base_addr=0, start, bytes 78 56 34 12 EF BE AD DE with in_valid held -> write (0,0x12345678) then (1,0xDEADBEEF), done pulses once in cycle after second write, busy falls with done.
REQ-034 LOAD_WORDS=2, base_addr=31, bytes 01 00 00 00 02 00 00 00 -> writes (31,0x00000001) then (0,0x00000002).
REQ-035 in_valid toggled 1,0,0,1,0,1,1 carrying 44 33 22 11 -> single write of 0x11223344 in cycle after last accepted byte, no earlier write.
REQ-036 in_valid held high through WRITE cycle with byte AA -> in_ready=0 that cycle, AA consumed as byte 0 of next word.
REQ-037 rst asserted after 2 bytes accepted -> no write, all outputs at reset values next cycle; new start with base_addr=5 and 4 bytes writes entry 5 with only new bytes.
REQ-038 start pulsed while busy with different base_addr -> ignored; write addresses follow original base_addr.

Source files
------------

// File: rtl/icache_loader.sv
// icache_loader: assembles a little-endian byte stream into 32-bit instructions
// and writes LOAD_WORDS of them into consecutive icache entries from base_addr.
module icache_loader #(
    parameter int unsigned LOAD_WORDS = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [4:0]  base_addr,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        write,
    output logic [4:0]  write_addr,
    output logic [31:0] write_data,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {StIdle, StCollect, StWrite, StDone} state_e;

    state_e      state_q, state_d;
    logic [4:0]  addr_q, addr_d;
    logic [1:0]  byte_cnt_q, byte_cnt_d;
    logic [5:0]  word_cnt_q, word_cnt_d;
    // Bytes 0..2 only; byte 3 goes straight into the write data register.
    logic [23:0] asm_q, asm_d;
    logic [4:0]  waddr_q, waddr_d;
    logic [31:0] wdata_q, wdata_d;

    logic        accept;

    // Outputs come from registers only, so no input reaches them combinationally.
    assign in_ready   = (state_q == StCollect);
    assign write      = (state_q == StWrite);
    assign busy       = (state_q != StIdle);
    assign done       = (state_q == StDone);
    assign write_addr = waddr_q;
    assign write_data = wdata_q;

    assign accept = in_ready & in_valid;

    // Next-state logic: load sequencing, byte assembly and address/counter updates.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        byte_cnt_d = byte_cnt_q;
        word_cnt_d = word_cnt_q;
        asm_d      = asm_q;
        waddr_d    = waddr_q;
        wdata_d    = wdata_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    addr_d     = base_addr;
                    byte_cnt_d = 2'd0;
                    word_cnt_d = 6'd0;
                    asm_d      = 24'd0;
                    state_d    = StCollect;
                end
            end
            StCollect: begin
                if (accept) begin
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    unique case (byte_cnt_q)
                        2'd0: asm_d[7:0]   = in_data;
                        2'd1: asm_d[15:8]  = in_data;
                        2'd2: asm_d[23:16] = in_data;
                        2'd3: begin
                            // Capture the write beat now so it is visible in WRITE.
                            waddr_d = addr_q;
                            wdata_d = {in_data, asm_q};
                            state_d = StWrite;
                        end
                        default: ;
                    endcase
                end
            end
            StWrite: begin
                addr_d     = addr_q + 5'd1;
                word_cnt_d = word_cnt_q + 6'd1;
                asm_d      = 24'd0;
                if (word_cnt_q == 6'(LOAD_WORDS - 1)) begin
                    state_d = StDone;
                end else begin
                    state_d = StCollect;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // State register with synchronous reset that also discards any partial word.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            addr_q     <= 5'd0;
            byte_cnt_q <= 2'd0;
            word_cnt_q <= 6'd0;
            asm_q      <= 24'd0;
            waddr_q    <= 5'd0;
            wdata_q    <= 32'd0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            byte_cnt_q <= byte_cnt_d;
            word_cnt_q <= word_cnt_d;
            asm_q      <= asm_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
        end
    end

endmodule

// File: tb/tb_icache_loader.sv
// Directed bench for icache_loader with LOAD_WORDS=2.
module tb_icache_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [4:0]  base_addr;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        write;
    logic [4:0]  write_addr;
    logic [31:0] write_data;
    logic        busy;
    logic        done;

    int tests = 0;
    int fails = 0;

    icache_loader #(.LOAD_WORDS(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .base_addr  (base_addr),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .write      (write),
        .write_addr (write_addr),
        .write_data (write_data),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    // Advance one rising edge and settle.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Present a byte and hold it until an edge where in_ready was high.
    task automatic send_byte(input logic [7:0] b);
        logic acc;
        int   guard;
        in_valid = 1'b1;
        in_data  = b;
        guard    = 0;
        acc      = in_ready;
        tick();
        while (!acc && guard < 20) begin
            acc = in_ready;
            tick();
            guard++;
        end
        if (!acc) chk("byte_accept_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; base_addr = 5'd0; in_valid = 1'b0; in_data = 8'h00;
        tick(); tick();
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_write", {31'd0, write}, 32'd0);
        chk("rst_waddr", {27'd0, write_addr}, 32'd0);
        chk("rst_wdata", write_data, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        rst = 1'b0;
        tick();

        // Two-word load from entry 0, in_valid held throughout.
        base_addr = 5'd0; start = 1'b1;
        tick();
        start = 1'b0;
        chk("t1_collect_ready", {31'd0, in_ready}, 32'd1);
        chk("t1_busy", {31'd0, busy}, 32'd1);
        send_byte(8'h78); send_byte(8'h56); send_byte(8'h34);
        chk("t1_no_early_write", {31'd0, write}, 32'd0);
        send_byte(8'h12);
        chk("t1_w0_write", {31'd0, write}, 32'd1);
        chk("t1_w0_addr", {27'd0, write_addr}, 32'd0);
        chk("t1_w0_data", write_data, 32'h12345678);
        chk("t1_w0_ready_low", {31'd0, in_ready}, 32'd0);
        send_byte(8'hEF);
        chk("t1_write_one_cycle", {31'd0, write}, 32'd0);
        send_byte(8'hBE); send_byte(8'hAD); send_byte(8'hDE);
        chk("t1_w1_write", {31'd0, write}, 32'd1);
        chk("t1_w1_addr", {27'd0, write_addr}, 32'd1);
        chk("t1_w1_data", write_data, 32'hDEADBEEF);
        in_valid = 1'b0;
        tick();
        chk("t1_done", {31'd0, done}, 32'd1);
        chk("t1_done_busy", {31'd0, busy}, 32'd1);
        chk("t1_done_nowrite", {31'd0, write}, 32'd0);
        chk("t1_hold_addr", {27'd0, write_addr}, 32'd1);
        chk("t1_hold_data", write_data, 32'hDEADBEEF);
        tick();
        chk("t1_done_pulse", {31'd0, done}, 32'd0);
        chk("t1_idle_busy", {31'd0, busy}, 32'd0);
        chk("t1_idle_ready", {31'd0, in_ready}, 32'd0);

        // Address wrap from entry 31; AA-style byte held across WRITE.
        base_addr = 5'd31; start = 1'b1;
        tick();
        start = 1'b0;
        send_byte(8'h01); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        chk("t2_w0_addr", {27'd0, write_addr}, 32'd31);
        chk("t2_w0_data", write_data, 32'h00000001);
        in_data = 8'hAA;
        chk("t2_write_ready_low", {31'd0, in_ready}, 32'd0);
        send_byte(8'hAA); send_byte(8'h00); send_byte(8'h00); send_byte(8'h02);
        chk("t2_w1_addr", {27'd0, write_addr}, 32'd0);
        chk("t2_w1_data", write_data, 32'h020000AA);
        in_valid = 1'b0;
        tick(); tick();
        chk("t2_idle", {31'd0, busy}, 32'd0);

        // Gapped in_valid pattern 1,0,0,1,0,1,1.
        base_addr = 5'd10; start = 1'b1;
        tick();
        start = 1'b0;
        in_valid = 1'b1; in_data = 8'h44; tick();
        in_valid = 1'b0; in_data = 8'h99; tick();
        chk("t3_gap_nowrite_a", {31'd0, write}, 32'd0);
        tick();
        in_valid = 1'b1; in_data = 8'h33; tick();
        in_valid = 1'b0; in_data = 8'h77; tick();
        in_valid = 1'b1; in_data = 8'h22; tick();
        chk("t3_gap_nowrite_b", {31'd0, write}, 32'd0);
        in_data = 8'h11; tick();
        in_valid = 1'b0;
        chk("t3_write", {31'd0, write}, 32'd1);
        chk("t3_addr", {27'd0, write_addr}, 32'd10);
        chk("t3_data", write_data, 32'h11223344);
        tick();

        // Reset after two bytes of the second word.
        send_byte(8'h55); send_byte(8'h66);
        in_valid = 1'b0;
        rst = 1'b1;
        tick();
        chk("t4_rst_ready", {31'd0, in_ready}, 32'd0);
        chk("t4_rst_write", {31'd0, write}, 32'd0);
        chk("t4_rst_waddr", {27'd0, write_addr}, 32'd0);
        chk("t4_rst_wdata", write_data, 32'd0);
        chk("t4_rst_busy", {31'd0, busy}, 32'd0);
        chk("t4_rst_done", {31'd0, done}, 32'd0);
        rst = 1'b0;
        base_addr = 5'd5; start = 1'b1;
        tick();
        start = 1'b0;
        send_byte(8'hA1); send_byte(8'hB2); send_byte(8'hC3); send_byte(8'hD4);
        chk("t4_write", {31'd0, write}, 32'd1);
        chk("t4_addr", {27'd0, write_addr}, 32'd5);
        chk("t4_data", write_data, 32'hD4C3B2A1);

        // start with a different base while busy must be ignored.
        start = 1'b1; base_addr = 5'd20;
        send_byte(8'h0F); send_byte(8'h0E); send_byte(8'h0D); send_byte(8'h0C);
        start = 1'b0; in_valid = 1'b0;
        chk("t5_addr", {27'd0, write_addr}, 32'd6);
        chk("t5_data", write_data, 32'h0C0D0E0F);
        tick();
        chk("t5_done", {31'd0, done}, 32'd1);
        tick();
        chk("t5_idle", {31'd0, busy}, 32'd0);

        // Reset wins over start in the same cycle.
        rst = 1'b1; start = 1'b1; base_addr = 5'd3;
        tick();
        chk("t6_rst_prio", {31'd0, busy}, 32'd0);
        rst = 1'b0; start = 1'b0;
        tick();
        chk("t6_stay_idle", {31'd0, busy}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
